// File: rtl/fp_result_unloader.sv
// fp_result_unloader: captures an N-bit result word on LOAD and streams it out
// as N/W chunks of W bits, MSB chunk first, over a valid/ready handshake.
// Optional feature macro: FP_UNLOAD_PARITY_EN appends one XOR-parity chunk
// after the data chunks; OUT_LAST then marks the parity chunk only.
module fp_result_unloader #(
  parameter int N = 16,
  parameter int W = 4
) (
  input  logic         CLK,
  input  logic         CLR,
  input  logic [N-1:0] D,
  input  logic         LOAD,
  output logic [W-1:0] OUT_DATA,
  output logic         OUT_VALID,
  input  logic         OUT_READY,
  output logic         OUT_LAST,
  output logic         BUSY,
  output logic         LOAD_ERR
);

  localparam int NC = N / W;
`ifdef FP_UNLOAD_PARITY_EN
  localparam int NCHUNK = NC + 1;
`else
  localparam int NCHUNK = NC;
`endif
  // Counter also has to reach NC when the parity chunk is present.
  localparam int CW = $clog2(NC + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(NCHUNK - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   shreg_q, shreg_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   data_q, data_d;
  logic           valid_q, valid_d;
  logic           last_q, last_d;
  logic           busy_q, busy_d;
  logic           lerr_q, lerr_d;
  logic           xfer;
  logic           capture;

`ifdef FP_UNLOAD_PARITY_EN
  logic [W-1:0]   par_q, par_d;
`endif

  // A chunk moves whenever the registered valid meets the consumer's ready.
  assign xfer    = valid_q & OUT_READY;
  assign capture = (state_q == IDLE) & LOAD;

  // State register with synchronous active-low clear.
  always_ff @(posedge CLK) begin
    if (!CLR) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state: leave IDLE on LOAD, return after the final chunk is taken.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (LOAD) state_d = SEND;
      SEND:    if (xfer && last_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: capture on load, shift and count on non-final transfers.
  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
`ifdef FP_UNLOAD_PARITY_EN
    par_d   = par_q;
`endif
    if (capture) begin
      shreg_d = D;
      cnt_d   = '0;
`ifdef FP_UNLOAD_PARITY_EN
      par_d   = '0;
`endif
    end else if ((state_q == SEND) && xfer && !last_q) begin
      shreg_d = shreg_q << W;
      cnt_d   = cnt_q + CW'(1);
`ifdef FP_UNLOAD_PARITY_EN
      // Only data chunks are non-final transfers, so this folds in exactly NC chunks.
      par_d   = par_q ^ shreg_q[N-1 -: W];
`endif
    end
  end

  // Output next values, computed from next state so every output is a flop.
  always_comb begin
    valid_d = (state_d == SEND);
    busy_d  = (state_d == SEND);
    last_d  = (state_d == SEND) && (cnt_d == LAST_CNT);
    lerr_d  = (state_q == SEND) && LOAD;
    data_d  = '0;
    if (state_d == SEND) begin
`ifdef FP_UNLOAD_PARITY_EN
      data_d = (cnt_d == CW'(NC)) ? par_d : shreg_d[N-1 -: W];
`else
      data_d = shreg_d[N-1 -: W];
`endif
    end
  end

  // Datapath and output registers; clear aborts any word in flight.
  always_ff @(posedge CLK) begin
    if (!CLR) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      lerr_q  <= 1'b0;
`ifdef FP_UNLOAD_PARITY_EN
      par_q   <= '0;
`endif
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      lerr_q  <= lerr_d;
`ifdef FP_UNLOAD_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign OUT_DATA  = data_q;
  assign OUT_VALID = valid_q;
  assign OUT_LAST  = last_q;
  assign BUSY      = busy_q;
  assign LOAD_ERR  = lerr_q;

endmodule

// File: tb/tb_fp_result_unloader.sv
// Testbench for fp_result_unloader: directed scenarios plus random traffic,
// checked every cycle against a queue-based reference model.
module tb_fp_result_unloader;

  localparam int N  = 16;
  localparam int W  = 4;
  localparam int NC = N / W;

  logic         CLK = 1'b0;
  logic         CLR;
  logic [N-1:0] D;
  logic         LOAD;
  logic [W-1:0] OUT_DATA;
  logic         OUT_VALID;
  logic         OUT_READY;
  logic         OUT_LAST;
  logic         BUSY;
  logic         LOAD_ERR;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: chunks still owed for the current word, plus the error pulse.
  logic [W-1:0] m_q[$];
  logic         m_lerr = 1'b0;

  // Chunks observed crossing the handshake, and LOAD_ERR pulses seen.
  logic [W-1:0] rx[$];
  int           lerr_cnt;

  fp_result_unloader #(.N(N), .W(W)) dut (
    .CLK(CLK), .CLR(CLR), .D(D), .LOAD(LOAD),
    .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .OUT_LAST(OUT_LAST), .BUSY(BUSY), .LOAD_ERR(LOAD_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Build the chunk list the word should produce.
  task automatic push_word(input logic [N-1:0] w);
    logic [W-1:0] p;
    logic [W-1:0] c;
    p = '0;
    for (int k = 0; k < NC; k++) begin
      c = W'(w >> (N - W * (k + 1)));
      p = p ^ c;
      m_q.push_back(c);
    end
`ifdef FP_UNLOAD_PARITY_EN
    m_q.push_back(p);
`endif
  endtask

  // One clock: record handshake, advance model at the edge, check at the negedge.
  task automatic tick();
    if (OUT_VALID === 1'b1 && OUT_READY === 1'b1) rx.push_back(OUT_DATA);
    if (LOAD_ERR === 1'b1) lerr_cnt++;
    @(posedge CLK);
    if (!CLR) begin
      m_q.delete();
      m_lerr = 1'b0;
    end else begin
      m_lerr = LOAD && (m_q.size() > 0);
      if (m_q.size() > 0) begin
        if (OUT_READY) void'(m_q.pop_front());
      end else if (LOAD) begin
        push_word(D);
      end
    end
    @(negedge CLK);
    chk("valid", 32'(OUT_VALID), 32'(m_q.size() > 0));
    chk("busy",  32'(BUSY),      32'(m_q.size() > 0));
    chk("last",  32'(OUT_LAST),  32'(m_q.size() == 1));
    chk("data",  32'(OUT_DATA),  (m_q.size() > 0) ? 32'(m_q[0]) : 32'd0);
    chk("lerr",  32'(LOAD_ERR),  32'(m_lerr));
  endtask

  function automatic logic [31:0] rx_word();
    logic [31:0] w;
    w = '0;
    foreach (rx[i]) w = (w << W) | 32'(rx[i]);
    return w;
  endfunction

  function automatic logic [31:0] exp_word(input logic [N-1:0] d);
    logic [31:0] w;
    logic [W-1:0] p;
    w = 32'(d);
    p = '0;
    for (int k = 0; k < NC; k++) p = p ^ W'(d >> (W * k));
`ifdef FP_UNLOAD_PARITY_EN
    w = (w << W) | 32'(p);
`endif
    return w;
  endfunction

`ifdef FP_UNLOAD_PARITY_EN
  localparam int WLEN = NC + 1;
`else
  localparam int WLEN = NC;
`endif

  task automatic load_word(input logic [N-1:0] d);
    D = d; LOAD = 1'b1; tick();
    LOAD = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  logic [6:0] bp_pat;

  initial begin
    CLR = 1'b0; LOAD = 1'b1; D = 16'hFFFF; OUT_READY = 1'b1;
    rx.delete(); lerr_cnt = 0;
    @(negedge CLK);

    // Reset held with LOAD active: no capture, outputs zero.
    tick(); tick();
    chk("rst_data_zero", 32'(OUT_DATA), 32'd0);
    CLR = 1'b1; LOAD = 1'b0;
    idle(3);
    chk("rst_stays_idle", 32'(BUSY), 32'd0);

    // Basic unload with continuous ready.
    rx.delete();
    OUT_READY = 1'b1;
    load_word(16'h3C00);
    chk("basic_first_chunk", 32'(OUT_DATA), 32'h3);
    idle(WLEN + 1);
    chk("basic_len",  32'(rx.size()), 32'(WLEN));
    chk("basic_word", rx_word(), exp_word(16'h3C00));

    // Back-pressure with the listed ready pattern, then ready until done.
    rx.delete();
    OUT_READY = 1'b0;
    load_word(16'hC500);
    bp_pat = 7'b1011001; // applied LSB first: 1,0,0,1,1,0,1
    for (int i = 0; i < 7; i++) begin
      OUT_READY = bp_pat[i];
      tick();
    end
    OUT_READY = 1'b1;
    idle(4);
    chk("bp_len",  32'(rx.size()), 32'(WLEN));
    chk("bp_word", rx_word(), exp_word(16'hC500));

    // Load while busy is rejected with a single error pulse.
    rx.delete(); lerr_cnt = 0;
    load_word(16'h1234);
    tick();
    D = 16'hABCD; LOAD = 1'b1; tick();
    LOAD = 1'b0;
    idle(WLEN + 2);
    chk("busy_len",  32'(rx.size()), 32'(WLEN));
    chk("busy_word", rx_word(), exp_word(16'h1234));
    chk("busy_lerr_pulses", 32'(lerr_cnt), 32'd1);

    // Reset mid-word, then a fresh word.
    rx.delete();
    load_word(16'h7BFF);
    tick(); tick();
    chk("mid_two_sent", 32'(rx.size()), 32'd2);
    CLR = 1'b0; tick();
    chk("mid_valid_zero", 32'(OUT_VALID), 32'd0);
    CLR = 1'b1;
    rx.delete();
    idle(1);
    load_word(16'h0001);
    idle(WLEN + 1);
    chk("mid_new_word", rx_word(), exp_word(16'h0001));

    // Random traffic with occasional clears.
    for (int i = 0; i < 1500; i++) begin
      D         = N'($urandom);
      LOAD      = ($urandom_range(0, 3) == 0);
      OUT_READY = ($urandom_range(0, 2) != 0);
      CLR       = ($urandom_range(0, 60) != 0);
      tick();
    end
    CLR = 1'b1; LOAD = 1'b0; OUT_READY = 1'b1;
    idle(WLEN + 2);
    chk("final_idle", 32'(BUSY), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
